// File: rtl/pc_seq_pkg.sv
// ============================================================================
// Module      : pc_seq_pkg
// Description : Shared types for the fetch-side PC sequencer: FSM states,
//               PC source encoding and the default sequential increment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_seq_pkg;

  // Sequencer control states
  typedef enum logic [1:0] {
    ST_RESET = 2'b00,
    ST_RUN   = 2'b01,
    ST_FLUSH = 2'b10,
    ST_HALT  = 2'b11
  } seq_state_e;

  // Source of the most recent PC update, as reported on PCsrc
  typedef enum logic [1:0] {
    PCSRC_PLUS4  = 2'b00,
    PCSRC_BRANCH = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_HOLD   = 2'b11
  } pcsrc_e;

  localparam int DEFAULT_PC_INCR = 4;

endpackage

`default_nettype wire

// File: rtl/pc_next_mux.sv
// ============================================================================
// Module      : pc_next_mux
// Description : Combinational next-PC selector. Resolves redirect priority
//               (branch over jump), word-aligns redirect targets, flags
//               misaligned targets and decides hold/halt/advance.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_next_mux
  import pc_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PC_INCR    = DEFAULT_PC_INCR
) (
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic                  redirect_only,  // FLUSH: only redirects are honoured
  input  logic                  branch_taken,
  input  logic [DATA_WIDTH-1:0] branch_target,
  input  logic                  jump,
  input  logic [DATA_WIDTH-1:0] jump_target,
  input  logic                  halt,
  input  logic                  stall,
  input  logic                  imem_ready,
  output logic [DATA_WIDTH-1:0] pc_next,
  output pcsrc_e                pcsrc_next,
  output logic                  redirect,
  output logic                  halt_req,
  output logic                  advance,
  output logic                  misaligned
);

  // Priority select: branch (older) > jump (younger) > halt > hold > advance
  always_comb begin
    pc_next    = pc;
    pcsrc_next = PCSRC_HOLD;
    redirect   = 1'b0;
    halt_req   = 1'b0;
    advance    = 1'b0;
    misaligned = 1'b0;
    if (branch_taken) begin
      pc_next    = {branch_target[DATA_WIDTH-1:2], 2'b00};
      pcsrc_next = PCSRC_BRANCH;
      redirect   = 1'b1;
      misaligned = |branch_target[1:0];
    end else if (jump) begin
      pc_next    = {jump_target[DATA_WIDTH-1:2], 2'b00};
      pcsrc_next = PCSRC_JUMP;
      redirect   = 1'b1;
      misaligned = |jump_target[1:0];
    end else if (!redirect_only) begin
      if (halt) begin
        halt_req = 1'b1;
      end else if (!stall && imem_ready) begin
        pc_next    = pc + DATA_WIDTH'(PC_INCR);
        pcsrc_next = PCSRC_PLUS4;
        advance    = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module      : pc_sequencer
// Description : Fetch-stage program counter owner. Sequences PC through
//               advance, branch/jump redirect with a one-cycle flush bubble,
//               stall hold and halt. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    PC_INCR    = DEFAULT_PC_INCR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  branch_taken,
  input  logic [DATA_WIDTH-1:0] branch_target,
  input  logic                  jump,
  input  logic [DATA_WIDTH-1:0] jump_target,
  input  logic                  stall,
  input  logic                  halt,
  input  logic                  imem_ready,
  output logic [DATA_WIDTH-1:0] PC,
  output logic [1:0]            PCsrc,
  output logic                  fetch_valid,
  output logic                  flush,
  output logic                  misaligned,
  output logic                  halted,
  output logic [31:0]           fetch_count
);

  seq_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  pcsrc_e                pcsrc_q, pcsrc_d;
  logic                  fetch_valid_q, fetch_valid_d;
  logic                  flush_q, flush_d;
  logic                  misaligned_q, misaligned_d;
  logic                  halted_q, halted_d;
  logic [31:0]           fetch_count_q, fetch_count_d;

  logic [DATA_WIDTH-1:0] mux_pc;
  pcsrc_e                mux_src;
  logic                  mux_redirect, mux_halt, mux_advance, mux_misaligned;

  pc_next_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .PC_INCR    (PC_INCR)
  ) u_next_mux (
    .pc            (pc_q),
    .redirect_only (state_q == ST_FLUSH),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .halt          (halt),
    .stall         (stall),
    .imem_ready    (imem_ready),
    .pc_next       (mux_pc),
    .pcsrc_next    (mux_src),
    .redirect      (mux_redirect),
    .halt_req      (mux_halt),
    .advance       (mux_advance),
    .misaligned    (mux_misaligned)
  );

  // State and output registers; reset discards any pending redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RESET;
      pc_q          <= RESET_PC;
      pcsrc_q       <= PCSRC_HOLD;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      misaligned_q  <= 1'b0;
      halted_q      <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pcsrc_q       <= pcsrc_d;
      fetch_valid_q <= fetch_valid_d;
      flush_q       <= flush_d;
      misaligned_q  <= misaligned_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Next-state: RESET leaves unconditionally, FLUSH lasts one cycle unless re-redirected
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_RUN;
      ST_RUN: begin
        if (mux_redirect)  state_d = ST_FLUSH;
        else if (mux_halt) state_d = ST_HALT;
      end
      ST_FLUSH: state_d = mux_redirect ? ST_FLUSH : ST_RUN;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_RESET;
    endcase
  end

  // Output values for the next cycle; PC only moves in RUN/FLUSH
  always_comb begin
    pc_d          = pc_q;
    pcsrc_d       = pcsrc_q;
    misaligned_d  = 1'b0;
    fetch_count_d = fetch_count_q;
    if (state_q == ST_RUN || state_q == ST_FLUSH) begin
      pc_d         = mux_pc;
      pcsrc_d      = mux_src;
      misaligned_d = mux_misaligned;
      if (mux_advance) fetch_count_d = fetch_count_q + 32'd1;
    end
    fetch_valid_d = (state_d == ST_RUN);
    flush_d       = (state_d == ST_FLUSH);
    halted_d      = (state_d == ST_HALT);
  end

  assign PC          = pc_q;
  assign PCsrc       = pcsrc_q;
  assign fetch_valid = fetch_valid_q;
  assign flush       = flush_q;
  assign misaligned  = misaligned_q;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Scoreboard bench for pc_sequencer. Two instances (reset PC 0
//               and 0xFFFFFFF8) share stimulus; a reference model predicts
//               each cycle's registered outputs and a monitor compares.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        branch_taken = 1'b0, jump = 1'b0, halt = 1'b0, stall = 1'b0, imem_ready = 1'b0;
  logic [31:0] branch_target = '0, jump_target = '0;

  logic [31:0] pc_0, pc_1, cnt_0, cnt_1;
  logic [1:0]  src_0, src_1;
  logic        fv_0, fv_1, fl_0, fl_1, mis_0, mis_1, hal_0, hal_1;

  always #5 clk = ~clk;

  pc_sequencer #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000), .PC_INCR(4)) u_dut0 (
    .clk(clk), .rst(rst), .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .stall(stall), .halt(halt),
    .imem_ready(imem_ready), .PC(pc_0), .PCsrc(src_0), .fetch_valid(fv_0),
    .flush(fl_0), .misaligned(mis_0), .halted(hal_0), .fetch_count(cnt_0));

  pc_sequencer #(.DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFF8), .PC_INCR(4)) u_dut1 (
    .clk(clk), .rst(rst), .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .stall(stall), .halt(halt),
    .imem_ready(imem_ready), .PC(pc_1), .PCsrc(src_1), .fetch_valid(fv_1),
    .flush(fl_1), .misaligned(mis_1), .halted(hal_1), .fetch_count(cnt_1));

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  src;
    logic        fv, fl, mis, hal;
    logic [31:0] cnt;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: modes named after the behaviour they describe
  localparam int M_RESET = 0, M_RUN = 1, M_FLUSH = 2, M_HALT = 3;
  int          m_mode[2];
  logic [31:0] m_pc[2], m_cnt[2];
  logic [1:0]  m_src[2];
  logic        m_mis[2];
  logic [31:0] reset_pc[2] = '{32'h0000_0000, 32'hFFFF_FFF8};

  task automatic model_step(input int k);
    if (rst) begin
      m_mode[k] = M_RESET; m_pc[k] = reset_pc[k]; m_src[k] = 2'b11;
      m_cnt[k] = 0; m_mis[k] = 1'b0;
      return;
    end
    m_mis[k] = 1'b0;
    if (m_mode[k] == M_RESET) begin
      m_mode[k] = M_RUN;
    end else if (m_mode[k] == M_RUN || m_mode[k] == M_FLUSH) begin
      if (branch_taken || jump) begin
        logic [31:0] t;
        t = branch_taken ? branch_target : jump_target;
        m_pc[k]   = t & ~32'h3;
        m_mis[k]  = (t % 4) != 0;
        m_src[k]  = branch_taken ? 2'b01 : 2'b10;
        m_mode[k] = M_FLUSH;
      end else if (m_mode[k] == M_FLUSH) begin
        m_src[k] = 2'b11; m_mode[k] = M_RUN;
      end else if (halt) begin
        m_src[k] = 2'b11; m_mode[k] = M_HALT;
      end else if (stall || !imem_ready) begin
        m_src[k] = 2'b11;
      end else begin
        m_pc[k] = m_pc[k] + 32'd4; m_src[k] = 2'b00; m_cnt[k] = m_cnt[k] + 1;
      end
    end
  endtask

  function automatic obs_t model_obs(input int k);
    obs_t o;
    o.pc = m_pc[k]; o.src = m_src[k]; o.mis = m_mis[k]; o.cnt = m_cnt[k];
    o.fv  = (m_mode[k] == M_RUN);
    o.fl  = (m_mode[k] == M_FLUSH);
    o.hal = (m_mode[k] == M_HALT);
    return o;
  endfunction

  // Apply one cycle of inputs and queue the predicted post-edge outputs
  task automatic drive(input logic r, input logic bt, input logic [31:0] btg,
                       input logic jp, input logic [31:0] jtg,
                       input logic h, input logic s, input logic rdy);
    @(negedge clk);
    rst = r; branch_taken = bt; branch_target = btg; jump = jp; jump_target = jtg;
    halt = h; stall = s; imem_ready = rdy;
    for (int k = 0; k < 2; k++) begin
      model_step(k);
      exp_q.push_back(model_obs(k));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d at %0t: got %h, expected %h", name, k, $time, act, exp);
    end
  endtask

  task automatic compare(input int k, input obs_t e);
    obs_t a;
    if (k == 0) a = '{pc: pc_0, src: src_0, fv: fv_0, fl: fl_0, mis: mis_0, hal: hal_0, cnt: cnt_0};
    else        a = '{pc: pc_1, src: src_1, fv: fv_1, fl: fl_1, mis: mis_1, hal: hal_1, cnt: cnt_1};
    check("pc",          k, a.pc, e.pc);
    check("pcsrc",       k, 32'(a.src), 32'(e.src));
    check("fetch_valid", k, 32'(a.fv), 32'(e.fv));
    check("flush",       k, 32'(a.fl), 32'(e.fl));
    check("misaligned",  k, 32'(a.mis), 32'(e.mis));
    check("halted",      k, 32'(a.hal), 32'(e.hal));
    check("fetch_count", k, a.cnt, e.cnt);
  endtask

  // Monitor: every edge with a pending prediction is compared just after the edge
  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() >= 2) begin
        e = exp_q.pop_front(); compare(0, e);
        e = exp_q.pop_front(); compare(1, e);
      end
    end
  end

  function automatic logic [31:0] rand_target();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 255));
      2:       return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      default: return $urandom & 32'h0000_0FFC;
    endcase
  endfunction

  initial begin
    // Reset, then free-running advance (dut1 wraps past 0xFFFFFFFC)
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    idle(4);
    // Simultaneous branch and jump: branch wins
    drive(1'b0, 1'b1, 32'h80, 1'b1, 32'h40, 1'b0, 1'b0, 1'b1);
    idle(2);
    // Misaligned jump target
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h103, 1'b0, 1'b0, 1'b1);
    idle(2);
    // Redirect with memory not ready, then stall for three cycles
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
    idle(1);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    idle(2);
    // Redirect during the flush bubble, halt ignored there
    drive(1'b0, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h302, 1'b1, 1'b1, 1'b1);
    idle(2);
    // Halt, later branch ignored, reset releases
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 32'h500, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    idle(2);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    idle(3);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 63) == 0),
            ($urandom_range(0, 9) == 0), rand_target(),
            ($urandom_range(0, 9) == 0), rand_target(),
            ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 4) != 0));
    end
    @(negedge clk);
    @(negedge clk);
    check("queue_drained", 0, 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
